// File: rtl/fault_detector.sv
// Compares an observed word against its golden reference, classifies the mismatch,
// and keeps total/consecutive fault counters with a sticky alarm.
module fault_detector #(
    parameter int DataSize    = 32,
    parameter int SizeFault   = 3,
    parameter int AlarmThresh = 4,
    parameter int CountWidth  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inValid,
    input  logic [DataSize-1:0]   goldenIn,
    input  logic [DataSize-1:0]   dataIn,
    input  logic                  clear,
    output logic                  outValid,
    output logic [SizeFault-1:0]  faultType,
    output logic                  faultDetected,
    output logic [CountWidth-1:0] faultCount,
    output logic [CountWidth-1:0] consecCount,
    output logic                  alarm,
    output logic                  ready
);

    typedef enum logic [1:0] {
        WARMUP  = 2'd0,
        MONITOR = 2'd1,
        ALARM   = 2'd2
    } state_t;

    localparam logic [CountWidth-1:0] CountMax    = '1;
    localparam logic [CountWidth-1:0] CountThresh = CountWidth'(AlarmThresh);

    state_t                state_reg, state_next;
    logic                  warm_cnt_reg, warm_cnt_next;
    logic                  out_valid_reg, out_valid_next;
    logic [SizeFault-1:0]  fault_type_reg, fault_type_next;
    logic                  fault_det_reg, fault_det_next;
    logic [CountWidth-1:0] fault_count_reg, fault_count_next;
    logic [CountWidth-1:0] consec_count_reg, consec_count_next;
    logic                  alarm_reg, alarm_next;

    logic [DataSize-1:0]   flip_word;
    logic [DataSize-1:0]   shift_word;
    logic [SizeFault-1:0]  sample_code;

    // Code-1 pattern: the four bits just below the top two forced to one.
    generate
        for (genvar gi = 0; gi < DataSize; gi++) begin : g_flip
            if (gi >= DataSize - 6 && gi <= DataSize - 3) begin : g_forced
                assign flip_word[gi] = 1'b1;
            end else begin : g_pass
                assign flip_word[gi] = goldenIn[gi];
            end
        end
    endgenerate

    assign shift_word = {goldenIn[DataSize-2:0], 1'b0};

    // Equality against X/Z evaluates false, so such words fall through to code 3.
    always_comb begin
        sample_code = SizeFault'(3);
        if (dataIn == goldenIn) begin
            sample_code = SizeFault'(0);
        end else if (dataIn == flip_word) begin
            sample_code = SizeFault'(1);
        end else if (dataIn == shift_word) begin
            sample_code = SizeFault'(2);
        end
    end

    always_comb begin
        state_next        = state_reg;
        warm_cnt_next     = warm_cnt_reg;
        out_valid_next    = 1'b0;
        fault_type_next   = fault_type_reg;
        fault_det_next    = fault_det_reg;
        fault_count_next  = fault_count_reg;
        consec_count_next = consec_count_reg;
        alarm_next        = alarm_reg;

        case (state_reg)
            WARMUP: begin
                warm_cnt_next = 1'b1;
                if (warm_cnt_reg) begin
                    state_next = MONITOR;
                end
            end
            default: begin
                if (clear) begin
                    fault_count_next  = '0;
                    consec_count_next = '0;
                    alarm_next        = 1'b0;
                    state_next        = MONITOR;
                end else if (inValid) begin
                    out_valid_next  = 1'b1;
                    fault_type_next = sample_code;
                    fault_det_next  = (sample_code != '0);
                    if (sample_code != '0) begin
                        if (fault_count_reg != CountMax) begin
                            fault_count_next = fault_count_reg + CountWidth'(1);
                        end
                        if (consec_count_reg != CountMax) begin
                            consec_count_next = consec_count_reg + CountWidth'(1);
                        end
                    end else begin
                        consec_count_next = '0;
                    end
                    if (consec_count_next >= CountThresh) begin
                        alarm_next = 1'b1;
                        state_next = ALARM;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg        <= WARMUP;
            warm_cnt_reg     <= 1'b0;
            out_valid_reg    <= 1'b0;
            fault_type_reg   <= '0;
            fault_det_reg    <= 1'b0;
            fault_count_reg  <= '0;
            consec_count_reg <= '0;
            alarm_reg        <= 1'b0;
        end else begin
            state_reg        <= state_next;
            warm_cnt_reg     <= warm_cnt_next;
            out_valid_reg    <= out_valid_next;
            fault_type_reg   <= fault_type_next;
            fault_det_reg    <= fault_det_next;
            fault_count_reg  <= fault_count_next;
            consec_count_reg <= consec_count_next;
            alarm_reg        <= alarm_next;
        end
    end

    assign ready         = (state_reg != WARMUP);
    assign outValid      = out_valid_reg;
    assign faultType     = fault_type_reg;
    assign faultDetected = fault_det_reg;
    assign faultCount    = fault_count_reg;
    assign consecCount   = consec_count_reg;
    assign alarm         = alarm_reg;

endmodule

// File: tb/tb_fault_detector.sv
// Randomized + directed bench for fault_detector: a queue scoreboard fed by a
// behavioural model, with a negedge monitor that checks transactions and state.
module tb_fault_detector;

    localparam int DW  = 32;
    localparam int SF  = 3;
    localparam int TH  = 4;
    localparam int CW  = 6;
    localparam int MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          inValid = 1'b0;
    logic          clear = 1'b0;
    logic [DW-1:0] goldenIn = '0;
    logic [DW-1:0] dataIn = '0;
    logic          outValid;
    logic [SF-1:0] faultType;
    logic          faultDetected;
    logic [CW-1:0] faultCount;
    logic [CW-1:0] consecCount;
    logic          alarm;
    logic          ready;

    fault_detector #(
        .DataSize(DW), .SizeFault(SF), .AlarmThresh(TH), .CountWidth(CW)
    ) dut (
        .clk(clk), .rst(rst), .inValid(inValid), .goldenIn(goldenIn),
        .dataIn(dataIn), .clear(clear), .outValid(outValid),
        .faultType(faultType), .faultDetected(faultDetected),
        .faultCount(faultCount), .consecCount(consecCount),
        .alarm(alarm), .ready(ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ft;
        bit fd;
        int fc;
        int cc;
        bit al;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Behavioural model state
    int m_warm = 0;
    int m_fc = 0;
    int m_cc = 0;
    bit m_al = 1'b0;
    int m_ft = 0;
    bit m_fd = 1'b0;

    function automatic int classify(logic [31:0] g, logic [31:0] d);
        logic [31:0] dbl;
        dbl = g + g;
        if (d === g) return 0;
        if (d === (g | 32'h3C00_0000)) return 1;
        if (d === dbl) return 2;
        return 3;
    endfunction

    task automatic check(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(bit v, logic [31:0] g, logic [31:0] d, bit c);
        int k;
        exp_t e;
        if (m_warm < 2) begin
            m_warm++;
        end else if (c) begin
            m_fc = 0;
            m_cc = 0;
            m_al = 1'b0;
        end else if (v) begin
            k = classify(g, d);
            m_ft = k;
            m_fd = (k != 0);
            if (k != 0) begin
                if (m_fc < MAX) m_fc++;
                if (m_cc < MAX) m_cc++;
            end else begin
                m_cc = 0;
            end
            if (m_cc >= TH) m_al = 1'b1;
            e.ft = m_ft; e.fd = m_fd; e.fc = m_fc; e.cc = m_cc; e.al = m_al;
            exp_q.push_back(e);
        end
    endtask

    task automatic step(bit v, logic [31:0] g, logic [31:0] d, bit c);
        inValid  = v;
        goldenIn = g;
        dataIn   = d;
        clear    = c;
        @(posedge clk);
        model_edge(v, g, d, c);
        #1;
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_ready", ready, 0);
        check("rst_outValid", outValid, 0);
        check("rst_faultType", faultType, 0);
        check("rst_faultDetected", faultDetected, 0);
        check("rst_faultCount", faultCount, 0);
        check("rst_consecCount", consecCount, 0);
        check("rst_alarm", alarm, 0);
        m_warm = 0; m_fc = 0; m_cc = 0; m_al = 1'b0; m_ft = 0; m_fd = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Monitor: transaction scoreboard plus continuous state comparison
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            check("ready", ready, (m_warm >= 2));
            check("faultType", faultType, m_ft);
            check("faultDetected", faultDetected, m_fd);
            check("faultCount", faultCount, m_fc);
            check("consecCount", consecCount, m_cc);
            check("alarm", alarm, m_al);
            if (exp_q.size() == 0) begin
                if (outValid) check("unexpected_outValid", outValid, 0);
            end else begin
                e = exp_q.pop_front();
                check("txn_outValid", outValid, 1);
                check("txn_faultType", faultType, e.ft);
                check("txn_faultDetected", faultDetected, e.fd);
                check("txn_faultCount", faultCount, e.fc);
                check("txn_consecCount", consecCount, e.cc);
                check("txn_alarm", alarm, e.al);
                $display("txn ft=%0d fd=%0b fc=%0d cc=%0d alarm=%0b", faultType,
                         faultDetected, faultCount, consecCount, alarm);
            end
        end
    end

    initial begin
        logic [31:0] g;
        logic [31:0] d;
        int          sel;

        // Release reset with inValid held high: two ignored warmup cycles
        inValid = 1'b1; goldenIn = 32'h2A; dataIn = 32'h2A;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        step(1, 32'h2A, 32'h2A, 0);
        check("warm1_ready", ready, 0);
        step(1, 32'h2A, 32'h2A, 0);
        check("warm2_ready", ready, 1);

        // One sample of each code
        step(1, 32'h2A, 32'h2A, 0);
        step(1, 32'h2A, 32'h3C00_002A, 0);
        step(1, 32'h2A, 32'h54, 0);
        step(1, 32'h2A, 32'hFFFF_FFFF, 0);
        check("code3_type", faultType, 3);
        check("seq_faultCount", faultCount, 3);
        check("seq_consecCount", consecCount, 3);
        step(0, 0, 0, 0);

        // Four consecutive faults raise the alarm; a clean sample keeps it
        step(0, 0, 0, 1);
        repeat (4) step(1, 32'h2A, 32'h54, 0);
        check("alarm_on4", alarm, 1);
        step(1, 32'h2A, 32'h2A, 0);
        check("clean_consec", consecCount, 0);
        check("alarm_sticky", alarm, 1);

        // clear wins over a simultaneous sample
        step(1, 32'h2A, 32'h54, 1);
        check("clr_outValid", outValid, 0);
        check("clr_alarm", alarm, 0);
        check("clr_faultCount", faultCount, 0);

        // zero word: code 0 takes priority over code 2
        step(1, 32'h0, 32'h0, 0);
        check("zero_type", faultType, 0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            g = $urandom;
            if ($urandom_range(0, 3) == 0) g = g & 32'h0000_00FF;
            sel = $urandom_range(0, 3);
            case (sel)
                0:       d = g;
                1:       d = g | 32'h3C00_0000;
                2:       d = g << 1;
                default: d = $urandom;
            endcase
            step(($urandom_range(0, 9) < 8), g, d, ($urandom_range(0, 19) == 0));
        end

        // Saturation of both counters
        step(0, 0, 0, 1);
        repeat (MAX + 5) step(1, 32'h2A, 32'hFFFF_FFFF, 0);
        check("sat_faultCount", faultCount, MAX);
        check("sat_consecCount", consecCount, MAX);
        step(0, 0, 0, 0);

        // Asynchronous reset mid-cycle, then warmup restarts
        mid_reset();
        step(1, 32'h2A, 32'h54, 0);
        step(1, 32'h2A, 32'h54, 0);
        step(1, 32'h2A, 32'h54, 0);
        step(0, 0, 0, 0);
        check("post_reset_faultCount", faultCount, 1);
        step(0, 0, 0, 0);

        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
